dmem_dump_reader: RTL and testbench

- Read-side engine that walks the user (debug) read port of the data memory and streams its contents out as bytes on a valid/ready interface.
- The byte stream feeds the board UART transmitter or a display shifter.
- The block drives useraddr and samples userdout. That port is a combinational read, so data is valid in the same cycle the address is driven.
- The block never writes memory. It runs concurrently with CPU accesses on the other port.

---
 rtl/dmem_dump_reader_if.sv | 26 ++
 rtl/dmem_dump_reader.sv | 116 +++++++++++
 tb/tb_dmem_dump_reader.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_dump_reader_if.sv
// rtl/dmem_dump_reader_if.sv - byte stream and memory user read port bundle for dmem_dump_reader
interface dmem_dump_reader_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] useraddr;
  logic [15:0]       userdout;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output useraddr,
    input  userdout,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  useraddr,
    output userdout,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/dmem_dump_reader.sv
// rtl/dmem_dump_reader.sv - walks the data memory user read port and streams words out MSB byte first
module dmem_dump_reader #(
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 31,
  parameter bit HEADER_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  dmem_dump_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
  localparam logic [7:0]        SYNC = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_HI,
    S_LO,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       word_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              hs;

  // A byte leaves only when the consumer takes it; ready with no valid byte is ignored.
  assign hs = tx_valid_q && bus.tx_ready;

  // Dump sequencer; every output is a register so the consumer sees clean edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= '0;
            busy_q <= 1'b1;
            if (HEADER_EN) begin
              tx_data_q  <= SYNC;
              tx_valid_q <= 1'b1;
              state_q    <= S_HDR;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_HDR: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // The read port is combinational, so this edge takes the pre-edge snapshot.
          word_q     <= bus.userdout;
          tx_data_q  <= bus.userdout[15:8];
          tx_valid_q <= 1'b1;
          state_q    <= S_HI;
        end
        S_HI: begin
          if (hs) begin
            tx_data_q <= word_q[7:0];
            state_q   <= S_LO;
          end else begin
            tx_data_q <= word_q[15:8];
          end
        end
        S_LO: begin
          if (hs) begin
            tx_valid_q <= 1'b0;
            // Equality termination keeps the counter from ever wrapping.
            if (addr_q == LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.useraddr = addr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_dmem_dump_reader.sv
// tb/tb_dmem_dump_reader.sv - scoreboard bench for dmem_dump_reader
module tb_dmem_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_a, start_b;
  logic busy_a, busy_b, done_a, done_b;

  dmem_dump_reader_if #(.ADDR_W(5)) bus_a ();
  dmem_dump_reader_if #(.ADDR_W(5)) bus_b ();

  logic [15:0] mem_a [32];
  logic [15:0] mem_b [32];

  assign bus_a.userdout = mem_a[bus_a.useraddr];
  assign bus_b.userdout = mem_b[bus_b.useraddr];

  dmem_dump_reader u_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_a),
    .busy_o  (busy_a),
    .done_o  (done_a),
    .bus     (bus_a)
  );

  dmem_dump_reader #(.ADDR_W(5), .LAST_ADDR(3), .HEADER_EN(1'b0)) u_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_b),
    .busy_o  (busy_b),
    .done_o  (done_b),
    .bus     (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  bit rnd_ready_a = 1'b0;
  bit time_chk_a  = 1'b0;
  int done_cnt_a  = 0;
  int done_cnt_b  = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Reference model: a dump is the sync byte (if enabled) then each word high byte first.
  task automatic push_dump_a(input int ov_addr, input logic [15:0] ov_val);
    logic [15:0] w;
    exp_a.push_back(8'hA5);
    for (int i = 0; i < 32; i++) begin
      w = (i == ov_addr) ? ov_val : mem_a[i];
      exp_a.push_back(w[15:8]);
      exp_a.push_back(w[7:0]);
    end
  endtask

  task automatic push_dumps_b(input int n);
    for (int d = 0; d < n; d++)
      for (int i = 0; i < 4; i++) begin
        exp_b.push_back(mem_b[i][15:8]);
        exp_b.push_back(mem_b[i][7:0]);
      end
  endtask

  // Consumer ready drivers, changed well clear of the sampling edges.
  initial begin
    bus_a.tx_ready = 1'b0;
    bus_b.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus_a.tx_ready = rnd_ready_a ? ($urandom_range(0, 9) < 3) : 1'b1;
      bus_b.tx_ready = ($urandom_range(0, 1) == 1);
    end
  end

  // Monitor for the full-size dumper.
  int         n_a = 0, rise_a = 0, bytes_a = 0;
  bit         pv_a = 0, prdy_a = 0, pbusy_a = 0, pdone_a = 0;
  logic [7:0] pdata_a = '0;
  logic [4:0] paddr_a = '0;
  always @(negedge clk) begin
    logic [7:0] e;
    n_a++;
    if (!rst_n) begin
      pv_a = 0; pbusy_a = 0; pdone_a = 0;
    end else begin
      if (pv_a && !prdy_a) begin
        check(bus_a.tx_valid === 1'b1, "a_stall_valid", int'(bus_a.tx_valid), 1);
        check(bus_a.tx_data === pdata_a, "a_stall_data", int'(bus_a.tx_data), int'(pdata_a));
      end
      if (pbusy_a && busy_a)
        check(bus_a.useraddr >= paddr_a, "a_addr_mono", int'(bus_a.useraddr), int'(paddr_a));
      if (pbusy_a && !busy_a && !pdone_a)
        check(busy_a, "a_busy_drop", int'(busy_a), 1);
      if (busy_a && !pbusy_a) begin
        rise_a  = n_a;
        bytes_a = 0;
      end
      if (bus_a.tx_valid && bus_a.tx_ready) begin
        bytes_a++;
        check(exp_a.size() != 0, "a_unexpected_byte", int'(bus_a.tx_data), 0);
        if (exp_a.size() != 0) begin
          e = exp_a.pop_front();
          check(bus_a.tx_data === e, "a_byte", int'(bus_a.tx_data), int'(e));
        end
      end
      if (done_a) begin
        done_cnt_a++;
        check(!pdone_a, "a_done_width", int'(pdone_a), 0);
        check(busy_a, "a_busy_at_done", int'(busy_a), 1);
        check(bytes_a == 65, "a_dump_len", bytes_a, 65);
        check(exp_a.size() == 0, "a_exp_left", exp_a.size(), 0);
        if (time_chk_a)
          check(n_a - rise_a == 97, "a_done_latency", n_a - rise_a, 97);
      end
      pv_a    = bus_a.tx_valid;
      prdy_a  = bus_a.tx_ready;
      pdata_a = bus_a.tx_data;
      paddr_a = bus_a.useraddr;
      pbusy_a = busy_a;
      pdone_a = done_a;
    end
  end

  // Monitor for the short, header-less dumper.
  int bytes_b = 0, low_b = 0;
  bit pbusy_b = 0, pdone_b = 0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      pbusy_b = 0; pdone_b = 0;
    end else begin
      if (!busy_b) low_b++;
      if (busy_b && !pbusy_b) begin
        if (done_cnt_b > 0) check(low_b == 1, "b_idle_gap", low_b, 1);
        low_b   = 0;
        bytes_b = 0;
      end
      if (bus_b.tx_valid && bus_b.tx_ready) begin
        bytes_b++;
        check(exp_b.size() != 0, "b_unexpected_byte", int'(bus_b.tx_data), 0);
        if (exp_b.size() != 0) begin
          e = exp_b.pop_front();
          check(bus_b.tx_data === e, "b_byte", int'(bus_b.tx_data), int'(e));
        end
      end
      if (done_b) begin
        done_cnt_b++;
        check(!pdone_b, "b_done_width", int'(pdone_b), 0);
        check(bytes_b == 8, "b_dump_len", bytes_b, 8);
      end
      pbusy_b = busy_b;
      pdone_b = done_b;
    end
  end

  task automatic pulse_start_a();
    @(posedge clk);
    #2 start_a = 1'b1;
    @(posedge clk);
    #2 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int d0, input string name);
    int k = 0;
    while (done_cnt_a == d0 && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check(done_cnt_a > d0, name, done_cnt_a, d0 + 1);
    repeat (3) @(posedge clk);
  endtask

  // Poll once per cycle, after ready has settled, for a given address and valid/data state.
  task automatic poll_a(input logic [4:0] addr, input bit need_valid, input bit need_data,
                        input logic [7:0] data, input string name);
    bit found = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      @(posedge clk);
      #3;
      if (bus_a.useraddr == addr && (!need_valid || bus_a.tx_valid) &&
          (!need_data || bus_a.tx_data == data))
        found = 1;
    end
    check(found, name, int'(bus_a.useraddr), int'(addr));
  endtask

  initial begin
    int d0;
    int dones;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = 16'h1000 + 16'(i);
      mem_b[i] = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check(busy_a == 1'b0, "rst_busy", int'(busy_a), 0);
    check(done_a == 1'b0, "rst_done", int'(done_a), 0);
    check(bus_a.tx_valid == 1'b0, "rst_valid", int'(bus_a.tx_valid), 0);
    check(bus_a.useraddr == 5'd0, "rst_addr", int'(bus_a.useraddr), 0);
    check(bus_a.tx_data == 8'h00, "rst_data", int'(bus_a.tx_data), 0);
    check(busy_b == 1'b0, "rst_busy_b", int'(busy_b), 0);

    // Start held high: back-to-back short dumps, stopped after the third.
    push_dumps_b(3);
    start_b = 1'b1;
    dones = 0;
    for (int k = 0; k < 400 && dones < 3; k++) begin
      @(posedge clk);
      #3;
      if (done_b) dones++;
      if (dones == 3) start_b = 1'b0;
    end
    start_b = 1'b0;
    repeat (10) @(posedge clk);
    check(done_cnt_b == 3, "b_done_count", done_cnt_b, 3);
    check(exp_b.size() == 0, "b_exp_left", exp_b.size(), 0);
    check(busy_b == 1'b0, "b_idle_after", int'(busy_b), 0);

    // Ready tied high: exact latency.
    time_chk_a = 1'b1;
    push_dump_a(-1, 16'h0);
    d0 = done_cnt_a;
    pulse_start_a();
    wait_done_a(d0, "a_done_plain");
    time_chk_a = 1'b0;

    // Random 30% ready.
    rnd_ready_a = 1'b1;
    push_dump_a(-1, 16'h0);
    d0 = done_cnt_a;
    pulse_start_a();
    wait_done_a(d0, "a_done_stall");

    // CPU write before word 5 is fetched is reflected.
    push_dump_a(5, 16'hBEEF);
    d0 = done_cnt_a;
    pulse_start_a();
    poll_a(5'd2, 1'b0, 1'b0, 8'h00, "a_poll_addr2");
    mem_a[5] = 16'hBEEF;
    wait_done_a(d0, "a_done_write_before");
    mem_a[5] = 16'h1005;

    // CPU write right after word 5 was captured is not reflected.
    push_dump_a(-1, 16'h0);
    d0 = done_cnt_a;
    pulse_start_a();
    poll_a(5'd5, 1'b1, 1'b0, 8'h00, "a_poll_addr5");
    mem_a[5] = 16'hBEEF;
    wait_done_a(d0, "a_done_write_after");
    mem_a[5] = 16'h1005;

    // A second start mid-dump is ignored.
    push_dump_a(-1, 16'h0);
    d0 = done_cnt_a;
    pulse_start_a();
    poll_a(5'd10, 1'b0, 1'b0, 8'h00, "a_poll_addr10");
    start_a = 1'b1;
    @(posedge clk);
    #2 start_a = 1'b0;
    wait_done_a(d0, "a_done_restart_ignored");

    // Reset while sending the low byte of word 12.
    rnd_ready_a = 1'b0;
    push_dump_a(-1, 16'h0);
    pulse_start_a();
    poll_a(5'd12, 1'b1, 1'b1, 8'h0C, "a_poll_lo12");
    rst_n = 1'b0;
    #1;
    check(bus_a.tx_valid == 1'b0, "a_rst_mid_valid", int'(bus_a.tx_valid), 0);
    check(busy_a == 1'b0, "a_rst_mid_busy", int'(busy_a), 0);
    check(bus_a.useraddr == 5'd0, "a_rst_mid_addr", int'(bus_a.useraddr), 0);
    exp_a.delete();
    d0 = done_cnt_a;
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check(done_cnt_a == d0, "a_rst_no_done", done_cnt_a, d0);

    // Fresh dump after reset, random contents and random ready.
    rnd_ready_a = 1'b1;
    for (int i = 0; i < 32; i++) mem_a[i] = 16'($urandom);
    push_dump_a(-1, 16'h0);
    d0 = done_cnt_a;
    pulse_start_a();
    wait_done_a(d0, "a_done_random");

    repeat (5) @(posedge clk);
    check(exp_a.size() == 0, "a_final_exp_left", exp_a.size(), 0);
    check(done_cnt_a == 6, "a_done_total", done_cnt_a, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
